// File: rtl/junction_cycle_ctrl_pkg.sv
// Shared constants for the junction sequencer, layer top and memory wrappers:
// FSM state codes and sizing helpers derived from the layer geometry.
package junction_cycle_ctrl_pkg;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRun   = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;

   // Cycles needed to stream one sample's p*fo weights, z per cycle.
   function automatic int unsigned calc_cpc(input int unsigned p, input int unsigned fo,
                                            input int unsigned z);
      return (p * fo) / z;
   endfunction

   // Cycles in one sweep over the preceding layer.
   function automatic int unsigned calc_sw(input int unsigned p, input int unsigned z);
      return p / z;
   endfunction

   // Index width; a single-cycle sample still needs a one-bit address.
   function automatic int unsigned calc_idx_w(input int unsigned cpc);
      return (cpc > 1) ? $clog2(cpc) : 1;
   endfunction

endpackage

// File: rtl/junction_cycle_ctrl_valid_delay_pipe.sv
// Fixed-depth shift register carrying a valid flag and its payload; shifts every
// cycle so in-flight entries drain out regardless of the producer's state.
module valid_delay_pipe #(
   parameter int unsigned depth = 1,
   parameter int unsigned width = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [width-1:0] in_data,
   output logic             out_valid,
   output logic [width-1:0] out_data
);

   logic [depth-1:0] valid_q;
   logic [width-1:0] data_q [depth];

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < depth; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q[0] <= in_valid;
         data_q[0]  <= in_data;
         for (int unsigned i = 1; i < depth; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[depth-1];
   assign out_data  = data_q[depth-1];

endmodule

// File: rtl/junction_cycle_ctrl.sv
// Per-junction sequencer: steps one sample through cpc weight-block cycles, driving
// FF/BP/UP enables, the sigmoid-latency valid pipe and the ready/start/done handshake.
module junction_cycle_ctrl
   import junction_cycle_ctrl_pkg::*;
#(
   parameter int unsigned fo     = 2,
   parameter int unsigned fi     = 4,
   parameter int unsigned p      = 16,
   parameter int unsigned n      = 8,
   parameter int unsigned z      = 8,
   parameter int unsigned ff_lat = 1,
   localparam int unsigned cpc   = calc_cpc(p, fo, z),
   localparam int unsigned idx_w = calc_idx_w(cpc)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             ready,
   output logic             busy,
   output logic [idx_w-1:0] cycle_index,
   output logic             ff_en,
   output logic             ff_valid,
   output logic [idx_w-1:0] ff_index,
   output logic             bp_en,
   output logic             bp_first,
   output logic             bp_last,
   output logic             up_en,
   output logic             done
);

   localparam int unsigned      sw         = calc_sw(p, z);
   localparam logic [idx_w-1:0] last_idx   = idx_w'(cpc - 1);
   localparam logic [1:0]       drain_last = 2'(ff_lat - 1);

   if ((p % z) != 0 || ((p * fo) % z) != 0) begin : g_bad_z
      $error("p and p*fo must both be multiples of z");
   end
   // Both layers must agree on the number of junction edges.
   if ((p * fo) != (n * fi)) begin : g_bad_geometry
      $error("p*fo must equal n*fi");
   end
   if (ff_lat < 1 || ff_lat > 4) begin : g_bad_lat
      $error("ff_lat must be in 1..4");
   end

   logic [1:0]       state_q, state_d;
   logic [idx_w-1:0] idx_q, idx_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             run_d;
   logic             is_last;
   logic             en_q;
   logic             bp_first_q, bp_last_q, busy_q;
   logic [idx_w:0]   pipe_in, pipe_out;

   assign is_last = (idx_q == last_idx);
   assign ready   = (state_q == StIdle) || ((state_q == StRun) && is_last);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               idx_d   = '0;
            end
         end
         StRun: begin
            if (is_last) begin
               idx_d = '0;
               if (!start) begin
                  state_d = StDrain;
                  cnt_d   = '0;
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StDrain: begin
            if (cnt_q == drain_last) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   assign run_d = (state_d == StRun);

   // Enables are registered from next-state so they line up with cycle_index.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         cnt_q      <= '0;
         en_q       <= 1'b0;
         bp_first_q <= 1'b0;
         bp_last_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         en_q       <= run_d;
         bp_first_q <= run_d && (32'(idx_d) < sw);
         bp_last_q  <= run_d && (32'(idx_d) >= (cpc - sw));
         busy_q     <= (state_d != StIdle);
      end
   end

   assign busy        = busy_q;
   assign cycle_index = idx_q;
   assign ff_en       = en_q;
   assign bp_en       = en_q;
   assign up_en       = en_q;
   assign bp_first    = bp_first_q;
   assign bp_last     = bp_last_q;

   // The top bit tags the sample's final block so done leaves the pipe as a flop.
   assign pipe_in = {en_q && is_last, idx_q};

   valid_delay_pipe #(
      .depth(ff_lat),
      .width(idx_w + 1)
   ) u_ff_pipe (
      .clk      (clk),
      .reset    (reset),
      .in_valid (en_q),
      .in_data  (pipe_in),
      .out_valid(ff_valid),
      .out_data (pipe_out)
   );

   assign ff_index = pipe_out[idx_w-1:0];
   assign done     = pipe_out[idx_w];

endmodule
